// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// A round-robin grant in IDLE picks one operation. The operation is registered onto
// the ALU inputs (EXEC), and the ALU result and flags are captured into the owner's
// response channel. That channel is held until it is consumed (RESP).
module alu_arbiter #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  // requester 0
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [4:0]   req0_fn,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [N-1:0] rsp0_r,
  output logic [3:0]   rsp0_flags,
  // requester 1
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [4:0]   req1_fn,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp1_r,
  output logic [3:0]   rsp1_flags,
  // shared ALU
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [4:0]   alu_fn,
  input  logic [N-1:0] alu_r,
  input  logic         alu_flagn,
  input  logic         alu_flagc,
  input  logic         alu_flagv,
  input  logic         alu_flagz,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   owner;   // requester that owns the operation in flight
  logic   prio;    // requester favoured when both ask at once
  logic   grant0;
  logic   grant1;

  // Grant: the sole valid requester wins, or the prio side on contention; only in IDLE.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      grant0 = req0_valid & (~req1_valid | ~prio);
      grant1 = req1_valid & (~req0_valid |  prio);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Sequencer: accept -> drive ALU -> capture into owner's channel -> wait for consume.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      prio       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_fn     <= '0;
      rsp0_valid <= 1'b0;
      rsp0_r     <= '0;
      rsp0_flags <= '0;
      rsp1_valid <= 1'b0;
      rsp1_r     <= '0;
      rsp1_flags <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            owner  <= grant1;
            alu_a  <= grant1 ? req1_a  : req0_a;
            alu_b  <= grant1 ? req1_b  : req0_b;
            alu_fn <= grant1 ? req1_fn : req0_fn;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          // Only the owner's channel is touched; the other side keeps its last result.
          if (owner) begin
            rsp1_r     <= alu_r;
            rsp1_flags <= {alu_flagn, alu_flagc, alu_flagv, alu_flagz};
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_r     <= alu_r;
            rsp0_flags <= {alu_flagn, alu_flagc, alu_flagv, alu_flagz};
            rsp0_valid <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (owner ? rsp1_ready : rsp0_ready) begin
            if (owner) begin
              rsp1_valid <= 1'b0;
            end else begin
              rsp0_valid <= 1'b0;
            end
            prio  <= ~owner;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus randomized traffic.
// A transaction-level reference model is checked on every falling clock edge.
module tb_alu_arbiter;
  localparam int N = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                reset_n;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][N-1:0]   req_a;
  logic [1:0][N-1:0]   req_b;
  logic [1:0][4:0]     req_fn;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [1:0][N-1:0]   rsp_r;
  logic [1:0][3:0]     rsp_flags;
  logic [N-1:0]        alu_a, alu_b, alu_r;
  logic [4:0]          alu_fn;
  logic                alu_flagn, alu_flagc, alu_flagv, alu_flagz;
  logic                busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arbiter #(.N(N)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_a(req_a[0]), .req0_b(req_b[0]),
    .req0_fn(req_fn[0]), .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_r(rsp_r[0]),
    .rsp0_flags(rsp_flags[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_a(req_a[1]), .req1_b(req_b[1]),
    .req1_fn(req_fn[1]), .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_r(rsp_r[1]),
    .rsp1_flags(rsp_flags[1]),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_r(alu_r),
    .alu_flagn(alu_flagn), .alu_flagc(alu_flagc), .alu_flagv(alu_flagv), .alu_flagz(alu_flagz),
    .busy(busy)
  );

  // Stand-in ALU: add, subtract, otherwise xor; returns {N,C,V,Z, result}.
  function automatic logic [N+3:0] alu_calc(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [4:0] fn);
    logic [N:0]   s;
    logic [N-1:0] r;
    logic         c;
    logic         v;
    s = '0;
    case (fn)
      5'b00001: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[N-1:0];
        c = s[N];
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      5'b10001: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[N-1:0];
        c = ~s[N];
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      default: begin
        r = a ^ b;
        c = a[0];
        v = b[0];
      end
    endcase
    return {r[N-1], c, v, (r == '0), r};
  endfunction

  assign {alu_flagn, alu_flagc, alu_flagv, alu_flagz, alu_r} = alu_calc(alu_a, alu_b, alu_fn);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic              m_inflight = 1'b0;   // an accepted operation has not yet been consumed
  logic              m_done     = 1'b0;   // its result has been delivered
  logic              m_own      = 1'b0;
  logic              m_prio     = 1'b0;
  logic [N-1:0]      m_alu_a    = '0;
  logic [N-1:0]      m_alu_b    = '0;
  logic [4:0]        m_alu_fn   = '0;
  logic [1:0][N-1:0] m_rsp_r    = '0;
  logic [1:0][3:0]   m_rsp_f    = '0;
  logic [1:0]        m_rsp_v    = '0;
  wire  [N+3:0]      m_res      = alu_calc(m_alu_a, m_alu_b, m_alu_fn);

  // Who should be granted right now (-1: nobody).
  function automatic int winner();
    if (m_inflight) return -1;
    if (req_valid == 2'b11) return int'(m_prio);
    if (req_valid[0]) return 0;
    if (req_valid[1]) return 1;
    return -1;
  endfunction

  // Model update on the clock edge and on asynchronous reset.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_inflight <= 1'b0;
      m_done     <= 1'b0;
      m_own      <= 1'b0;
      m_prio     <= 1'b0;
      m_alu_a    <= '0;
      m_alu_b    <= '0;
      m_alu_fn   <= '0;
      m_rsp_r    <= '0;
      m_rsp_f    <= '0;
      m_rsp_v    <= '0;
    end else if (!m_inflight) begin
      if (winner() >= 0) begin
        m_own      <= (winner() == 1);
        m_alu_a    <= req_a[winner()];
        m_alu_b    <= req_b[winner()];
        m_alu_fn   <= req_fn[winner()];
        m_inflight <= 1'b1;
        m_done     <= 1'b0;
      end
    end else if (!m_done) begin
      m_rsp_r[m_own] <= m_res[N-1:0];
      m_rsp_f[m_own] <= m_res[N+3:N];
      m_rsp_v[m_own] <= 1'b1;
      m_done         <= 1'b1;
    end else if (rsp_ready[m_own]) begin
      m_rsp_v[m_own] <= 1'b0;
      m_prio         <= ~m_own;
      m_inflight     <= 1'b0;
    end
  end

  // Compare every DUT output against the model away from the active edge.
  always @(negedge clock) begin
    check("cmp_busy", busy, m_inflight);
    check("cmp_alu_a", alu_a, m_alu_a);
    check("cmp_alu_b", alu_b, m_alu_b);
    check("cmp_alu_fn", alu_fn, m_alu_fn);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cmp_req%0d_ready", i), req_ready[i], winner() == i);
      check($sformatf("cmp_rsp%0d_valid", i), rsp_valid[i], m_rsp_v[i]);
      check($sformatf("cmp_rsp%0d_r", i), rsp_r[i], m_rsp_r[i]);
      check($sformatf("cmp_rsp%0d_flags", i), rsp_flags[i], m_rsp_f[i]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input int idx, input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (rsp_valid[idx] !== 1'b1 && n < budget);
    if (rsp_valid[idx] !== 1'b1) check($sformatf("timeout_rsp%0d_valid", idx), 0, 1);
  endtask

  task automatic do_reset();
    step();
    req_valid = '0;
    reset_n   = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // One uncontended operation with rsp_ready high; returns the observed response.
  task automatic do_op(input int idx, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [4:0] fn, output logic [N-1:0] r, output logic [3:0] f);
    step();
    req_valid[idx] = 1'b1;
    req_a[idx] = a;
    req_b[idx] = b;
    req_fn[idx] = fn;
    rsp_ready[idx] = 1'b1;
    @(negedge clock);
    check("op_ready_in_idle", req_ready[idx], 1);
    check("op_busy_before", busy, 0);
    step();
    req_valid[idx] = 1'b0;
    @(negedge clock);
    check("op_exec_busy", busy, 1);
    check("op_exec_no_valid", rsp_valid[idx], 0);
    step();
    @(negedge clock);
    check("op_resp_valid", rsp_valid[idx], 1);
    r = rsp_r[idx];
    f = rsp_flags[idx];
    step();
    @(negedge clock);
    check("op_done_busy", busy, 0);
    check("op_done_valid", rsp_valid[idx], 0);
    check("op_r_retained", rsp_r[idx], r);
  endtask

  logic [N-1:0] r_obs;
  logic [3:0]   f_obs;
  int           wait_n;

  initial begin
    reset_n   = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_fn    = '0;
    rsp_ready = '0;
    #2 reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    @(negedge clock);
    check("reset_busy", busy, 0);
    check("reset_alu_fn", alu_fn, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp0_r", rsp_r[0], 0);

    // Single add on requester 0.
    do_op(0, 5, 3, 5'b00001, r_obs, f_obs);
    check("add_r", r_obs, 8);
    check("add_flags", f_obs, 4'b0000);

    // Subtract to zero on requester 1; requester 0's result untouched.
    do_op(1, 3, 3, 5'b10001, r_obs, f_obs);
    check("sub_r", r_obs, 0);
    check("sub_z", f_obs[0], 1);
    check("sub_n", f_obs[3], 0);
    check("sub_fn_held", alu_fn, 5'b10001);
    check("sub_rsp0_untouched", rsp_r[0], 8);

    // Contention straight after reset: requester 0 first, then 1, then 0 again.
    do_reset();
    req_valid = 2'b11;
    req_a[0] = 7; req_b[0] = 1; req_fn[0] = 5'b00001;
    req_a[1] = 2; req_b[1] = 2; req_fn[1] = 5'b00001;
    rsp_ready = 2'b11;
    @(negedge clock);
    check("cont_first_ready0", req_ready[0], 1);
    check("cont_first_ready1", req_ready[1], 0);
    wait_valid(0, 8);
    check("cont_rsp0_r", rsp_r[0], 8);
    wait_valid(1, 8);
    check("cont_rsp1_r", rsp_r[1], 4);
    wait_n = 0;
    do begin
      @(negedge clock);
      wait_n++;
    end while (req_ready == 2'b00 && wait_n < 8);
    check("cont_third_grant", req_ready, 2'b01);
    step();
    req_valid = '0;
    repeat (4) step();

    // Back-pressure: requester 0 stalls 5+ cycles while requester 1 waits.
    req_valid[0] = 1'b1; req_a[0] = 32'hFFFF_FFFF; req_b[0] = 1; req_fn[0] = 5'b00001;
    rsp_ready[0] = 1'b0;
    step();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1; req_a[1] = 10; req_b[1] = 20; req_fn[1] = 5'b00001;
    wait_valid(0, 8);
    r_obs = rsp_r[0];
    f_obs = rsp_flags[0];
    check("bp_r", r_obs, 0);
    check("bp_flags", f_obs, 4'b0101);
    repeat (5) begin
      @(negedge clock);
      check("bp_valid_held", rsp_valid[0], 1);
      check("bp_r_held", rsp_r[0], r_obs);
      check("bp_flags_held", rsp_flags[0], f_obs);
      check("bp_req1_blocked", req_ready[1], 0);
    end
    step();
    rsp_ready[0] = 1'b1;
    step();
    @(negedge clock);
    check("bp_req1_granted", req_ready[1], 1);
    step();
    req_valid[1] = 1'b0;
    repeat (4) step();

    // Reset while the operation is in EXEC.
    req_valid[0] = 1'b1; req_a[0] = 9; req_b[0] = 9; req_fn[0] = 5'b00001;
    rsp_ready[0] = 1'b1;
    step();
    req_valid[0] = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_fn", alu_fn, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp0_r", rsp_r[0], 0);
    check("rst_rsp1_flags", rsp_flags[1], 0);
    step();
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check("rst_no_response", rsp_valid, 0);
    end
    do_op(1, 100, 23, 5'b00001, r_obs, f_obs);
    check("rst_next_op_r", r_obs, 123);

    // Requester 1 pulses valid during requester 0's RESP: ignored entirely.
    step();
    req_valid[0] = 1'b1; req_a[0] = 1; req_b[0] = 2; req_fn[0] = 5'b00001;
    rsp_ready = 2'b00;
    step();
    req_valid[0] = 1'b0;
    wait_valid(0, 8);
    step();
    req_valid[1] = 1'b1; req_a[1] = 4; req_b[1] = 4; req_fn[1] = 5'b00001;
    @(negedge clock);
    check("wd_req1_not_ready", req_ready[1], 0);
    step();
    req_valid[1] = 1'b0;
    rsp_ready[0] = 1'b1;
    step();
    step();
    repeat (3) begin
      @(negedge clock);
      check("wd_no_rsp1", rsp_valid[1], 0);
      check("wd_idle", busy, 0);
    end

    // Randomized traffic, including withdrawals, stalls and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      step();
      reset_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < 2; i++) begin
        req_valid[i] = ($urandom_range(0, 1) == 1);
        rsp_ready[i] = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 3) == 0) begin
          req_a[i] = $urandom;
          req_b[i] = ($urandom_range(0, 3) == 0) ? req_a[i] : $urandom;
          case ($urandom_range(0, 2))
            0:       req_fn[i] = 5'b00001;
            1:       req_fn[i] = 5'b10001;
            default: req_fn[i] = 5'($urandom);
          endcase
        end
      end
    end
    step();
    reset_n   = 1'b1;
    req_valid = '0;
    rsp_ready = 2'b11;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
